// File: rtl/axi3_slave_mem.sv
// AXI3 slave endpoint over a byte-addressed memory; independent write (AW/W/B) and read (AR/R) FSMs.
// Latency: WReady 1 cycle after AW, BValid 1 cycle after last W beat, R beat 0 1 cycle after AR.
// Backpressure: BValid/RValid and their payload are held stable until BReady/RReady; 1 R beat/cycle.

module axi3_slave_mem #(
  parameter int DATAWIDTH = 32,
  parameter int SIZE      = 3,
  parameter int MEMBYTES  = 16384
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATAWIDTH/8-1:0] AWid,
  input  logic [DATAWIDTH/8-1:0] AWlen,
  input  logic [DATAWIDTH-1:0]   AWaddr,
  input  logic [SIZE-1:0]        AWsize,
  input  logic [SIZE-2:0]        AWburst,
  input  logic                   AWvalid,
  output logic                   AWready,
  input  logic [DATAWIDTH/8-1:0] WId,
  input  logic [DATAWIDTH/8-1:0] WStrb,
  input  logic [DATAWIDTH-1:0]   WData,
  input  logic                   WLast,
  input  logic                   WValid,
  output logic                   WReady,
  output logic [DATAWIDTH/8-1:0] BId,
  output logic [1:0]             BResp,
  output logic                   BValid,
  input  logic                   BReady,
  input  logic [DATAWIDTH/8-1:0] ARid,
  input  logic [DATAWIDTH/8-1:0] ARlen,
  input  logic [DATAWIDTH-1:0]   ARaddr,
  input  logic [SIZE-1:0]        ARsize,
  input  logic [SIZE-2:0]        ARburst,
  input  logic                   ARvalid,
  output logic                   ARready,
  output logic [DATAWIDTH/8-1:0] RId,
  output logic [DATAWIDTH-1:0]   RData,
  output logic [1:0]             RResp,
  output logic                   RLast,
  output logic                   RValid,
  input  logic                   RReady
);

  localparam int NB    = DATAWIDTH / 8;
  localparam int IW    = $clog2(MEMBYTES);
  localparam int MAXSZ = $clog2(NB);
  localparam logic [SIZE-2:0] BURST_FIXED = 2'b00;
  localparam logic [SIZE-2:0] BURST_WRAP  = 2'b10;
  localparam logic [SIZE-2:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [7:0] mem [MEMBYTES];

  w_state_e              w_state_q, w_state_d;
  logic [NB-1:0]         w_id_q, w_id_d, w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [DATAWIDTH-1:0]  w_addr_q, w_addr_d;
  logic [SIZE-1:0]       w_size_q, w_size_d;
  logic [SIZE-2:0]       w_burst_q, w_burst_d;
  logic                  w_err_q, w_err_d, w_berr_q, w_berr_d;
  logic                  w_hs, w_oob, w_last_beat;
  logic [IW-1:0]         w_idx;

  r_state_e              r_state_q, r_state_d;
  logic [NB-1:0]         r_id_q, r_id_d, r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [DATAWIDTH-1:0]  r_addr_q, r_addr_d, r_data_q, r_data_d;
  logic [SIZE-1:0]       r_size_q, r_size_d;
  logic [SIZE-2:0]       r_burst_q, r_burst_d;
  logic                  r_berr_q, r_berr_d, r_last_q, r_last_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic [DATAWIDTH-1:0]  ld_addr, ld_word;
  logic                  ld_berr, ld_oob, ld_en;
  logic [IW-1:0]         ld_idx;

  function automatic logic [DATAWIDTH-1:0] align(input logic [DATAWIDTH-1:0] a);
    return a & ~DATAWIDTH'(NB - 1);
  endfunction

  // Beat that would touch bytes past the end of the array.
  function automatic logic beat_oob(input logic [DATAWIDTH-1:0] a);
    logic [DATAWIDTH:0] top;
    top = {1'b0, align(a)} + (DATAWIDTH + 1)'(NB - 1);
    return top >= (DATAWIDTH + 1)'(MEMBYTES);
  endfunction

  function automatic logic [DATAWIDTH-1:0] next_addr(input logic [DATAWIDTH-1:0] a,
      input logic [NB-1:0] len, input logic [SIZE-1:0] size, input logic [SIZE-2:0] burst);
    logic [DATAWIDTH-1:0] incr, wmask;
    incr  = a + (DATAWIDTH'(1) << size);
    wmask = ((DATAWIDTH'(len) + DATAWIDTH'(1)) << size) - DATAWIDTH'(1);
    if (burst == BURST_FIXED)     return a;
    else if (burst == BURST_WRAP) return (a & ~wmask) | (incr & wmask);
    else                          return incr;
  endfunction

  function automatic logic burst_err(input logic [DATAWIDTH-1:0] a,
      input logic [NB-1:0] len, input logic [SIZE-1:0] size, input logic [SIZE-2:0] burst);
    logic bad;
    bad = (burst == BURST_RSVD) || (size > SIZE'(MAXSZ));
    if (burst == BURST_WRAP) begin
      if (!(len == NB'(1) || len == NB'(3) || len == NB'(7) || len == NB'(15))) bad = 1'b1;
      if ((a & ((DATAWIDTH'(1) << size) - DATAWIDTH'(1))) != '0) bad = 1'b1;
    end
    return bad;
  endfunction

  // Write FSM next state: latch AW, count W beats, accumulate error, hand off to B.
  always_comb begin
    w_state_d   = w_state_q;
    w_id_d      = w_id_q;
    w_len_d     = w_len_q;
    w_cnt_d     = w_cnt_q;
    w_addr_d    = w_addr_q;
    w_size_d    = w_size_q;
    w_burst_d   = w_burst_q;
    w_err_d     = w_err_q;
    w_berr_d    = w_berr_q;
    w_hs        = (w_state_q == W_DATA) && WValid;
    w_oob       = beat_oob(w_addr_q);
    w_last_beat = (w_cnt_q == w_len_q);
    w_idx       = IW'(align(w_addr_q));
    case (w_state_q)
      W_IDLE: if (AWvalid) begin
        w_state_d = W_DATA;
        w_id_d    = AWid;
        w_len_d   = AWlen;
        w_addr_d  = AWaddr;
        w_size_d  = AWsize;
        w_burst_d = AWburst;
        w_cnt_d   = '0;
        w_err_d   = 1'b0;
        w_berr_d  = burst_err(AWaddr, AWlen, AWsize, AWburst);
      end
      W_DATA: if (WValid) begin
        w_cnt_d  = w_cnt_q + NB'(1);
        w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
        if ((WId != w_id_q) || (WLast != w_last_beat) || w_oob) w_err_d = 1'b1;
        if (w_last_beat) w_state_d = W_RESP;
      end
      W_RESP: if (BReady) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_addr_q  <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      w_berr_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_addr_q  <= w_addr_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      w_berr_q  <= w_berr_d;
    end
  end

  // Byte-lane memory write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_hs && !w_berr_q && !w_oob) begin
      for (int i = 0; i < NB; i++) begin
        if (WStrb[i]) mem[w_idx + IW'(i)] <= WData[8*i +: 8];
      end
    end
  end

  // Address of the beat to load next: AR start address when idle, else the successor beat.
  always_comb begin
    ld_addr = ARaddr;
    ld_berr = burst_err(ARaddr, ARlen, ARsize, ARburst);
    if (r_state_q == R_DATA) begin
      ld_addr = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
      ld_berr = r_berr_q;
    end
    ld_oob  = beat_oob(ld_addr);
    ld_idx  = IW'(align(ld_addr));
    ld_word = '0;
    for (int i = 0; i < NB; i++) ld_word[8*i +: 8] = mem[ld_idx + IW'(i)];
  end

  // Read FSM next state: load beat 0 on AR, each accepted non-last beat loads the next one.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_addr_d  = r_addr_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_berr_d  = r_berr_q;
    r_last_d  = r_last_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    ld_en     = 1'b0;
    case (r_state_q)
      R_IDLE: if (ARvalid) begin
        r_state_d = R_DATA;
        r_id_d    = ARid;
        r_len_d   = ARlen;
        r_size_d  = ARsize;
        r_burst_d = ARburst;
        r_berr_d  = ld_berr;
        r_cnt_d   = '0;
        r_addr_d  = ld_addr;
        r_last_d  = (ARlen == '0);
        ld_en     = 1'b1;
      end
      R_DATA: if (RReady) begin
        if (r_last_q) begin
          r_state_d = R_IDLE;
          r_last_d  = 1'b0;
        end else begin
          r_cnt_d  = r_cnt_q + NB'(1);
          r_addr_d = ld_addr;
          r_last_d = ((r_cnt_q + NB'(1)) == r_len_q);
          ld_en    = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (ld_en) begin
      r_data_d = (ld_berr || ld_oob) ? '0 : ld_word;
      r_resp_d = (ld_berr || ld_oob) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Read FSM registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_addr_q  <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_berr_q  <= 1'b0;
      r_last_q  <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_addr_q  <= r_addr_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_berr_q  <= r_berr_d;
      r_last_q  <= r_last_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  assign AWready = (w_state_q == W_IDLE);
  assign WReady  = (w_state_q == W_DATA);
  assign BValid  = (w_state_q == W_RESP);
  assign BId     = w_id_q;
  assign BResp   = ((w_state_q == W_RESP) && (w_err_q || w_berr_q)) ? RESP_SLVERR : RESP_OKAY;
  assign ARready = (r_state_q == R_IDLE);
  assign RValid  = (r_state_q == R_DATA);
  assign RId     = r_id_q;
  assign RData   = r_data_q;
  assign RResp   = r_resp_q;
  assign RLast   = r_last_q;

endmodule
